// File: rtl/ucsbece154_icache_sa.sv
// ============================================================================
// ucsbece154_icache_sa
// ----------------------------------------------------------------------------
// Set-associative instruction cache sitting between the fetch stage and the
// SDRAM instruction memory model. Lines are filled by a burst of BLOCK_WORDS
// words. The requested word is forwarded as it arrives (early restart). A
// one-cycle Flush invalidates every line, and two counters track hits and
// fills.
//
// Ports
//   Clk            : clock, all state changes on the rising edge
//   Reset          : synchronous, active-high reset
//   ReadEnable     : fetch request from the pipeline
//   ReadAddress    : byte address of the instruction (bits [1:0] ignored)
//   Flush          : one-cycle pulse, invalidates all lines
//   Instruction    : fetched word, meaningful only while Ready is high
//   Ready          : Instruction is valid this cycle
//   Busy           : a line fill is in progress
//   MemReadAddress : line-aligned byte address of the current fill
//   MemReadRequest : fill request, held high for the whole burst
//   MemDataIn      : burst data from memory
//   MemDataReady   : one pulse per burst word, words delivered in order
//   HitCount       : number of lookups satisfied from the cache
//   MissCount      : number of fills started
// ============================================================================
module ucsbece154_icache_sa #(
  parameter int NUM_SETS    = 8,
  parameter int NUM_WAYS    = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ReadEnable,
  input  logic [31:0]          ReadAddress,
  input  logic                 Flush,
  output logic [31:0]          Instruction,
  output logic                 Ready,
  output logic                 Busy,
  output logic [31:0]          MemReadAddress,
  output logic                 MemReadRequest,
  input  logic [31:0]          MemDataIn,
  input  logic                 MemDataReady,
  output logic [CNT_WIDTH-1:0] HitCount,
  output logic [CNT_WIDTH-1:0] MissCount
);

  localparam int OB = $clog2(BLOCK_WORDS);
  localparam int IB = $clog2(NUM_SETS);
  localparam int TW = 30 - OB - IB;
  localparam int SW = (IB > 0) ? IB : 1;
  localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [31:0] LINE_MASK = ~(32'(BLOCK_WORDS * 4) - 32'd1);

  typedef enum logic {IDLE, FILL} cacheStateT;

  cacheStateT state, stateNext;

  logic [31:0]          dataMem  [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
  logic [TW-1:0]        tagMem   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  validMem [NUM_SETS];
  logic [WW-1:0]        rrPtr    [NUM_SETS];

  logic [31:0]   fillAddr;
  logic [WW-1:0] fillWay;
  logic [OB-1:0] fillCnt;
  logic          pendingFlush;

  logic [SW-1:0] reqSet, fillSet;
  logic [TW-1:0] reqTag, fillTag;
  logic [OB-1:0] reqOff, fillOff;

  logic          hit;
  logic [WW-1:0] hitWay;
  logic          haveInvalid;
  logic [WW-1:0] victimWay;

  logic lookupHit;
  logic startFill;
  logic beatLast;

  // Address fields. The set mask makes a single-set cache index set 0.
  assign reqSet  = SW'(ReadAddress >> (OB + 2)) & SW'(NUM_SETS - 1);
  assign reqTag  = TW'(ReadAddress >> (OB + 2 + IB));
  assign reqOff  = OB'(ReadAddress >> 2);
  assign fillSet = SW'(fillAddr >> (OB + 2)) & SW'(NUM_SETS - 1);
  assign fillTag = TW'(fillAddr >> (OB + 2 + IB));
  assign fillOff = OB'(fillAddr >> 2);

  // Tag compare across all ways of the addressed set. The victim is the
  // lowest-numbered invalid way, or the set's round-robin pointer if the
  // set is full.
  always_comb begin
    hit         = 1'b0;
    hitWay      = '0;
    haveInvalid = 1'b0;
    victimWay   = rrPtr[reqSet];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && validMem[reqSet][w] && (tagMem[reqSet][w] == reqTag)) begin
        hit    = 1'b1;
        hitWay = WW'(w);
      end
      if (!haveInvalid && !validMem[reqSet][w]) begin
        haveInvalid = 1'b1;
        victimWay   = WW'(w);
      end
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic and outputs. Every output is forced low during reset.
  // In FILL, the beat carrying the word that caused the miss is bypassed
  // straight to Instruction if the pipeline is still asking for that word.
  always_comb begin
    stateNext      = state;
    Ready          = 1'b0;
    Instruction    = '0;
    Busy           = 1'b0;
    MemReadRequest = 1'b0;
    MemReadAddress = '0;
    lookupHit      = 1'b0;
    startFill      = 1'b0;
    beatLast       = 1'b0;
    if (!Reset) begin
      case (state)
        IDLE: begin
          if (ReadEnable) begin
            if (hit) begin
              Ready       = 1'b1;
              Instruction = dataMem[reqSet][hitWay][reqOff];
              lookupHit   = 1'b1;
            end else begin
              startFill = 1'b1;
              stateNext = FILL;
            end
          end
        end
        FILL: begin
          Busy           = 1'b1;
          MemReadRequest = 1'b1;
          MemReadAddress = fillAddr & LINE_MASK;
          if (MemDataReady) begin
            if ((fillCnt == fillOff) && ReadEnable &&
                (ReadAddress[31:2] == fillAddr[31:2])) begin
              Ready       = 1'b1;
              Instruction = MemDataIn;
            end
            if (fillCnt == OB'(BLOCK_WORDS - 1)) begin
              beatLast  = 1'b1;
              stateNext = IDLE;
            end
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Line data and tags. These arrays need no reset because valid bits
  // gate every use.
  always_ff @(posedge Clk) begin
    if (!Reset && (state == FILL) && MemDataReady) begin
      dataMem[fillSet][fillWay][fillCnt] <= MemDataIn;
      if (beatLast) tagMem[fillSet][fillWay] <= fillTag;
    end
  end

  // Control state: valid bits, replacement pointers, fill bookkeeping and
  // counters. A flush seen during a fill is deferred. The valid bits are
  // cleared only when the fill completes, so the line just written is
  // dropped as well.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        validMem[s] <= '0;
        rrPtr[s]    <= '0;
      end
      fillAddr     <= '0;
      fillWay      <= '0;
      fillCnt      <= '0;
      pendingFlush <= 1'b0;
      HitCount     <= '0;
      MissCount    <= '0;
    end else begin
      if (lookupHit) HitCount <= HitCount + CNT_WIDTH'(1);
      if (startFill) begin
        MissCount      <= MissCount + CNT_WIDTH'(1);
        fillAddr       <= ReadAddress;
        fillWay        <= victimWay;
        fillCnt        <= '0;
        rrPtr[reqSet]  <= (NUM_WAYS == 1) ? '0 : rrPtr[reqSet] + WW'(1);
      end
      if ((state == IDLE) && Flush) begin
        for (int s = 0; s < NUM_SETS; s++) validMem[s] <= '0;
      end
      if (state == FILL) begin
        if (Flush) pendingFlush <= 1'b1;
        if (MemDataReady) begin
          fillCnt <= fillCnt + OB'(1);
          if (beatLast) begin
            fillCnt      <= '0;
            pendingFlush <= 1'b0;
            if (pendingFlush || Flush) begin
              for (int s = 0; s < NUM_SETS; s++) validMem[s] <= '0;
            end else begin
              validMem[fillSet][fillWay] <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154_icache_sa.sv
// ============================================================================
// tb_ucsbece154_icache_sa
// ----------------------------------------------------------------------------
// Bench for the set-associative instruction cache with default parameters.
// The memory model returns, for each burst word, that word's byte address.
// So any correct fetch of address A must return A with bits [1:0] cleared.
// A line-level reference model tracks resident lines, replacement pointers,
// fill progress and counters, and is compared with the cache on every
// falling edge. Directed sequences add literal expectations.
// ============================================================================
module tb_ucsbece154_icache_sa;

  logic        Clk;
  logic        Reset;
  logic        ReadEnable;
  logic [31:0] ReadAddress;
  logic        Flush;
  logic [31:0] Instruction;
  logic        Ready;
  logic        Busy;
  logic [31:0] MemReadAddress;
  logic        MemReadRequest;
  logic [31:0] MemDataIn;
  logic        MemDataReady;
  logic [31:0] HitCount;
  logic [31:0] MissCount;

  int totalChecks = 0;
  int badChecks   = 0;

  ucsbece154_icache_sa dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .ReadEnable    (ReadEnable),
    .ReadAddress   (ReadAddress),
    .Flush         (Flush),
    .Instruction   (Instruction),
    .Ready         (Ready),
    .Busy          (Busy),
    .MemReadAddress(MemReadAddress),
    .MemReadRequest(MemReadRequest),
    .MemDataIn     (MemDataIn),
    .MemDataReady  (MemDataReady),
    .HitCount      (HitCount),
    .MissCount     (MissCount)
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Burst memory. It responds two time units after each rising edge, once
  // the cache's registered request is stable. It delivers one word per
  // cycle and restarts whenever the request drops.
  int memBeat = 0;
  always begin
    @(posedge Clk);
    #2;
    if (MemDataReady) memBeat++;
    if (!MemReadRequest) begin
      MemDataReady = 1'b0;
      MemDataIn    = 32'h0;
      memBeat      = 0;
    end else if (memBeat < 4) begin
      MemDataReady = 1'b1;
      MemDataIn    = MemReadAddress + 32'(4 * memBeat);
    end else begin
      MemDataReady = 1'b0;
    end
  end

  // Reference model: which line lives in each way, the round-robin pointer
  // per set, and an in-flight fill (address, beats seen, flush pending).
  int unsigned lineM  [8][4];
  bit          validM [8][4];
  int          rrM    [8];
  bit          fillingM;
  int unsigned fillAddrM;
  int          fillWayM;
  int          beatM;
  bit          pendM;
  int unsigned hitsM;
  int unsigned missesM;
  int unsigned mLine;
  int          mSet;
  bit          mHit;
  bit          mReady;
  int          mVictim;

  // Compare process: predict this cycle's outputs from the model and the
  // inputs, compare, then advance the model to the next edge.
  always @(negedge Clk) begin
    checkOutput("hitCount", HitCount, hitsM);
    checkOutput("missCount", MissCount, missesM);
    if (Reset) begin
      checkOutput("rstReady", {31'b0, Ready}, 32'h0);
      checkOutput("rstBusy", {31'b0, Busy}, 32'h0);
      checkOutput("rstMemReq", {31'b0, MemReadRequest}, 32'h0);
      checkOutput("rstMemAddr", MemReadAddress, 32'h0);
      checkOutput("rstInstr", Instruction, 32'h0);
      for (int s = 0; s < 8; s++) begin
        rrM[s] = 0;
        for (int w = 0; w < 4; w++) validM[s][w] = 1'b0;
      end
      fillingM = 1'b0;
      beatM    = 0;
      pendM    = 1'b0;
      hitsM    = 0;
      missesM  = 0;
    end else if (!fillingM) begin
      mLine = ReadAddress >> 4;
      mSet  = int'(mLine % 8);
      mHit  = 1'b0;
      for (int w = 0; w < 4; w++)
        if (validM[mSet][w] && lineM[mSet][w] == mLine) mHit = 1'b1;
      mReady = ReadEnable && mHit;
      checkOutput("idleReady", {31'b0, Ready}, {31'b0, mReady});
      checkOutput("idleBusy", {31'b0, Busy}, 32'h0);
      checkOutput("idleMemReq", {31'b0, MemReadRequest}, 32'h0);
      if (mReady) checkOutput("hitInstr", Instruction, ReadAddress & ~32'h3);
      if (mReady) begin
        hitsM++;
      end else if (ReadEnable) begin
        missesM++;
        mVictim = -1;
        for (int w = 0; w < 4; w++)
          if (mVictim < 0 && !validM[mSet][w]) mVictim = w;
        if (mVictim < 0) mVictim = rrM[mSet];
        rrM[mSet] = (rrM[mSet] + 1) % 4;
        fillingM  = 1'b1;
        fillAddrM = ReadAddress;
        fillWayM  = mVictim;
        beatM     = 0;
      end
      if (Flush)
        for (int s = 0; s < 8; s++)
          for (int w = 0; w < 4; w++) validM[s][w] = 1'b0;
    end else begin
      checkOutput("fillBusy", {31'b0, Busy}, 32'h1);
      checkOutput("fillMemReq", {31'b0, MemReadRequest}, 32'h1);
      checkOutput("fillMemAddr", MemReadAddress, fillAddrM & ~32'hF);
      mReady = MemDataReady && (beatM == int'((fillAddrM >> 2) % 4)) &&
               ReadEnable && ((ReadAddress >> 2) == (fillAddrM >> 2));
      checkOutput("fillReady", {31'b0, Ready}, {31'b0, mReady});
      if (mReady) checkOutput("bypassInstr", Instruction, fillAddrM & ~32'h3);
      if (Flush) pendM = 1'b1;
      if (MemDataReady) begin
        beatM++;
        if (beatM == 4) begin
          fillingM = 1'b0;
          mSet     = int'((fillAddrM >> 4) % 8);
          if (pendM) begin
            for (int s = 0; s < 8; s++)
              for (int w = 0; w < 4; w++) validM[s][w] = 1'b0;
          end else begin
            lineM[mSet][fillWayM]  = fillAddrM >> 4;
            validM[mSet][fillWayM] = 1'b1;
          end
          pendM = 1'b0;
        end
      end
    end
  end

  // Drive one cycle's inputs just after the rising edge. Return at edge+3,
  // once the memory has responded, so callers can check this cycle.
  task automatic applyStimulus(input logic re, input logic [31:0] addr,
                               input logic fl, input logic rst);
    @(posedge Clk);
    #1;
    ReadEnable  = re;
    ReadAddress = addr;
    Flush       = fl;
    Reset       = rst;
    #2;
  endtask

  task automatic nextCycle();
    @(posedge Clk);
    #3;
  endtask

  // Wait, bounded, for Ready and then check the delivered word.
  task automatic waitReady(input string name, input logic [31:0] expected);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (Ready) seen = 1'b1;
      else nextCycle();
    end
    checkOutput({name, "Seen"}, {31'b0, seen}, 32'h1);
    if (seen) checkOutput(name, Instruction, expected);
  endtask

  // Wait, bounded, for the fill to finish.
  task automatic waitIdle(input string name);
    bit idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      if (!Busy) idle = 1'b1;
      else nextCycle();
    end
    checkOutput(name, {31'b0, idle}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] sameSet [5] = '{32'h000, 32'h080, 32'h100, 32'h180, 32'h200};

  initial begin
    Reset        = 1'b1;
    ReadEnable   = 1'b0;
    ReadAddress  = 32'h0;
    Flush        = 1'b0;
    MemDataIn    = 32'h0;
    MemDataReady = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    // Cold miss at 0x18; the word is forwarded on the third burst beat.
    applyStimulus(1'b1, 32'h18, 1'b0, 1'b0);
    checkOutput("t1MissReady", {31'b0, Ready}, 32'h0);
    nextCycle();
    checkOutput("t1Busy", {31'b0, Busy}, 32'h1);
    checkOutput("t1MemAddr", MemReadAddress, 32'h10);
    waitReady("t1Bypass", 32'h18);
    checkOutput("t1MissCount", MissCount, 32'd1);
    applyStimulus(1'b0, 32'h18, 1'b0, 1'b0);
    waitIdle("t1Idle");

    // Another word of the same line hits in the same cycle.
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0);
    checkOutput("t2Ready", {31'b0, Ready}, 32'h1);
    checkOutput("t2Instr", Instruction, 32'h14);
    checkOutput("t2MemReq", {31'b0, MemReadRequest}, 32'h0);
    applyStimulus(1'b0, 32'h14, 1'b0, 1'b0);
    checkOutput("t2HitCount", HitCount, 32'd1);

    // Five lines into set 0: the fifth evicts way 0 (0x00).
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    foreach (sameSet[i]) begin
      applyStimulus(1'b1, sameSet[i], 1'b0, 1'b0);
      applyStimulus(1'b0, sameSet[i], 1'b0, 1'b0);
      waitIdle("t3Idle");
    end
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0);
    checkOutput("t3Hit80", {31'b0, Ready}, 32'h1);
    applyStimulus(1'b1, 32'h00, 1'b0, 1'b0);
    checkOutput("t3Miss00", {31'b0, Ready}, 32'h0);
    applyStimulus(1'b0, 32'h00, 1'b0, 1'b0);
    checkOutput("t3MissCount", MissCount, 32'd6);
    waitIdle("t3Idle2");

    // Flush in IDLE: the flush-cycle lookup still hits, the next misses.
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h14, 1'b0, 1'b0);
    waitIdle("t4Load");
    applyStimulus(1'b1, 32'h14, 1'b1, 1'b0);
    checkOutput("t4FlushCycleHit", {31'b0, Ready}, 32'h1);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0);
    checkOutput("t4MissAfterFlush", {31'b0, Ready}, 32'h0);
    applyStimulus(1'b0, 32'h14, 1'b0, 1'b0);
    checkOutput("t4MemReq", {31'b0, MemReadRequest}, 32'h1);
    waitIdle("t4Idle");

    // Flush during a fill: the early restart still happens, the line is dropped.
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    checkOutput("t5MissReady", {31'b0, Ready}, 32'h0);
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0);
    checkOutput("t5BypassReady", {31'b0, Ready}, 32'h1);
    checkOutput("t5BypassInstr", Instruction, 32'h40);
    applyStimulus(1'b0, 32'h40, 1'b0, 1'b0);
    waitIdle("t5Idle");
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    checkOutput("t5MissAgain", {31'b0, Ready}, 32'h0);
    applyStimulus(1'b0, 32'h40, 1'b0, 1'b0);
    waitIdle("t5Idle2");

    // Reset two beats into a fill abandons it and clears the counters.
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h20, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t6MemReq", {31'b0, MemReadRequest}, 32'h0);
    checkOutput("t6Busy", {31'b0, Busy}, 32'h0);
    checkOutput("t6HitCount", HitCount, 32'd0);
    checkOutput("t6MissCount", MissCount, 32'd0);
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0);
    checkOutput("t6Reread", {31'b0, Ready}, 32'h0);
    applyStimulus(1'b1, 32'h24, 1'b0, 1'b0);
    checkOutput("t6OtherWord", {31'b0, Ready}, 32'h0);
    applyStimulus(1'b0, 32'h24, 1'b0, 1'b0);
    checkOutput("t6MissCount1", MissCount, 32'd1);
    waitIdle("t6Idle");
    applyStimulus(1'b1, 32'h24, 1'b0, 1'b0);
    checkOutput("t6HitReady", {31'b0, Ready}, 32'h1);
    checkOutput("t6HitInstr", Instruction, 32'h24);
    applyStimulus(1'b0, 32'h24, 1'b0, 1'b0);
    nextCycle();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
